// File: rtl/instr_scroll_disp_if.sv
// instr_scroll_disp_if: capture/browse inputs and display outputs of instr_scroll_disp.
interface instr_scroll_disp_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned HIST_DEPTH = 4
);
  localparam int unsigned IW = $clog2(HIST_DEPTH);

  logic                    instr_valid;
  logic [31:0]             instr;
  logic                    hist_prev;
  logic [7*NUM_DIGITS-1:0] hex;
  logic [IW-1:0]           hist_idx;

  modport master (output instr_valid, instr, hist_prev, input hex, hist_idx);
  modport slave  (input instr_valid, instr, hist_prev, output hex, hist_idx);
endinterface

// File: rtl/instr_scroll_disp.sv
// instr_scroll_disp: captures RV32I instructions into a short history, decodes the
// selected entry into "mnemonic + rd" and scrolls it over an active-low 7-seg bank.
// Macro INSTR_SCROLL_DISP_HIST_EN enables multi-entry history and browsing; when it is
// undefined only the newest instruction is held and hist_prev is ignored.
module instr_scroll_disp #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned SCROLL_DIV = 25_000_000
) (
  input logic                clk,
  input logic                reset,
  instr_scroll_disp_if.slave bus
);
  localparam int unsigned IW      = $clog2(HIST_DEPTH);
  localparam int unsigned CW      = IW + 1;
  localparam int unsigned DW      = $clog2(SCROLL_DIV + 1);
  localparam bit          SCROLL  = (NUM_DIGITS < 9);
  localparam int          POS_MAX = SCROLL ? 9 - int'(NUM_DIGITS) : 0;

  localparam logic [6:0] G_A  = 7'b0001000, G_D = 7'b0100001, G_I  = 7'b1001111;
  localparam logic [6:0] G_S  = 7'b0010010, G_T = 7'b0000111, G_E  = 7'b0000110;
  localparam logic [6:0] G_N  = 7'b0101011, G_R = 7'b0101111, G_O  = 7'b1000000;
  localparam logic [6:0] G_L  = 7'b1000111, G_U = 7'b1000001, G_LU = 7'b1100011;
  localparam logic [6:0] G_B  = 7'b0000011, G_Q = 7'b0011000, G_J  = 7'b1110001;
  localparam logic [6:0] G_P  = 7'b0001100, G_C = 7'b1000110, G_X  = 7'b0110111;
  localparam logic [6:0] G_Y  = 7'b0010001, G_G = 7'b1000010, G_BL = 7'b1111111;
  localparam logic [13:0] BL2 = {2{G_BL}};
  localparam logic [20:0] BL3 = {3{G_BL}};

  logic [31:0] w_entry;
  logic        w_empty;
  logic        w_chg;
  logic        w_unused;

`ifdef INSTR_SCROLL_DISP_HIST_EN
  localparam logic [IW-1:0] IDX_MAX = IW'(HIST_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HIST_DEPTH);

  logic [31:0]   r_mem [HIST_DEPTH];
  logic [IW-1:0] r_wp;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_count;
  logic          w_prev_ok;

  // Capture wins over browse; a capture changes the view when following newest or saturated.
  always_comb begin
    w_prev_ok = bus.hist_prev && !bus.instr_valid && (r_count != '0);
    w_chg     = bus.instr_valid ? ((r_idx == '0) || (r_idx == IDX_MAX)) : w_prev_ok;
    w_entry   = r_mem[r_wp - IW'(1) - r_idx];
    w_empty   = (r_count == '0);
  end

  // Write pointer, fill count and view offset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_count <= '0;
      r_idx   <= '0;
    end else if (bus.instr_valid) begin
      r_wp <= r_wp + IW'(1);
      if (r_count != CNT_MAX) r_count <= r_count + CW'(1);
      if ((r_idx != '0) && (r_idx != IDX_MAX)) r_idx <= r_idx + IW'(1);
    end else if (w_prev_ok) begin
      if ({1'b0, r_idx} == r_count - CW'(1)) r_idx <= '0;
      else                                   r_idx <= r_idx + IW'(1);
    end
  end

  // History storage; not reset, and a capture coincident with reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && bus.instr_valid) r_mem[r_wp] <= bus.instr;
  end

  assign bus.hist_idx = r_idx;
  assign w_unused     = ^{w_entry[31], w_entry[29:15]};
`else
  logic [31:0] r_mem0;
  logic        r_full;

  // Single-entry history: every capture is a view change.
  always_comb begin
    w_chg   = bus.instr_valid;
    w_entry = r_mem0;
    w_empty = !r_full;
  end

  // Tracks whether anything has been captured since reset.
  always_ff @(posedge clk) begin
    if (reset)                r_full <= 1'b0;
    else if (bus.instr_valid) r_full <= 1'b1;
  end

  // Newest-instruction register.
  always_ff @(posedge clk) begin
    if (!reset && bus.instr_valid) r_mem0 <= bus.instr;
  end

  assign bus.hist_idx = IW'(0);
  assign w_unused     = ^{w_entry[31], w_entry[29:15], bus.hist_prev};
`endif

  function automatic logic [6:0] dig_glyph(input logic [3:0] d);
    case (d)
      4'd0: dig_glyph = 7'b1000000;
      4'd1: dig_glyph = 7'b1111001;
      4'd2: dig_glyph = 7'b0100100;
      4'd3: dig_glyph = 7'b0110000;
      4'd4: dig_glyph = 7'b0011001;
      4'd5: dig_glyph = 7'b0010010;
      4'd6: dig_glyph = 7'b0000010;
      4'd7: dig_glyph = 7'b1111000;
      4'd8: dig_glyph = 7'b0000000;
      default: dig_glyph = 7'b0010000;
    endcase
  endfunction

  logic [41:0] w_mn;
  logic        w_known;
  logic        w_has_rd;
  logic [4:0]  w_rd;
  logic [6:0]  w_msg [9];

  // Opcode/funct3/funct7[5] to six-glyph mnemonic and rd visibility.
  always_comb begin
    w_mn     = {BL3, BL3};
    w_known  = 1'b1;
    w_has_rd = 1'b1;
    case (w_entry[6:0])
      7'b0110011:
        case (w_entry[14:12])
          3'd0: w_mn = w_entry[30] ? {G_S, G_LU, G_B, BL3} : {G_A, G_D, G_D, BL3};
          3'd1: w_mn = {G_S, G_L, G_L, BL3};
          3'd2: w_mn = {G_S, G_L, G_T, BL3};
          3'd4: w_mn = {G_X, G_O, G_R, BL3};
          3'd6: w_mn = {G_O, G_R, BL2, BL2};
          3'd7: w_mn = {G_A, G_N, G_D, BL3};
          default: w_mn = {G_A, G_L, G_U, BL3};
        endcase
      7'b0010011:
        case (w_entry[14:12])
          3'd0: w_mn = {G_A, G_D, G_D, G_I, BL2};
          3'd4: w_mn = {G_X, G_O, G_R, G_I, BL2};
          3'd6: w_mn = {G_O, G_R, G_I, BL3};
          3'd7: w_mn = {G_A, G_N, G_D, G_I, BL2};
          default: w_mn = {G_A, G_L, G_U, G_I, BL2};
        endcase
      7'b0000011: w_mn = {G_L, G_O, G_A, G_D, BL2};
      7'b0100011: begin
        w_mn     = {G_S, G_T, G_O, G_R, BL2};
        w_has_rd = 1'b0;
      end
      7'b1100011: begin
        w_has_rd = 1'b0;
        case (w_entry[14:12])
          3'd0: w_mn = {G_B, G_E, G_Q, BL3};
          3'd1: w_mn = {G_B, G_N, G_E, BL3};
          3'd4: w_mn = {G_B, G_L, G_T, BL3};
          3'd5: w_mn = {G_B, G_G, G_E, BL3};
          default: w_mn = {G_B, G_R, G_A, BL3};
        endcase
      end
      7'b1101111: w_mn = {G_J, G_A, G_L, BL3};
      7'b1100111: w_mn = {G_J, G_A, G_L, G_R, BL2};
      7'b0110111: w_mn = {G_L, G_U, G_I, BL3};
      7'b0010111: w_mn = {G_A, G_U, G_I, G_P, G_C, G_BL};
      7'b1110011: begin
        w_mn     = {G_S, G_Y, G_S, G_T, G_E, G_N};
        w_has_rd = 1'b0;
      end
      default: begin
        w_known  = 1'b0;
        w_has_rd = 1'b0;
      end
    endcase
  end

  // Nine-character message: mnemonic, blank, two-digit rd.
  always_comb begin
    w_rd = w_entry[11:7];
    for (int unsigned i = 0; i < 6; i++) w_msg[i] = w_known ? w_mn[7*(5-i) +: 7] : G_BL;
    w_msg[6] = G_BL;
    w_msg[7] = w_has_rd ? dig_glyph(4'(w_rd / 5'd10)) : G_BL;
    w_msg[8] = w_has_rd ? dig_glyph(4'(w_rd % 5'd10)) : G_BL;
  end

  logic [3:0]              r_pos;
  logic [DW-1:0]           r_div;
  logic [7*NUM_DIGITS-1:0] w_hex;
  logic [7*NUM_DIGITS-1:0] r_hex;

  // Scroll prescaler and window position; restart on any view change.
  always_ff @(posedge clk) begin
    if (reset || w_chg) begin
      r_pos <= '0;
      r_div <= '0;
    end else if (SCROLL) begin
      if (r_div == DW'(SCROLL_DIV - 1)) begin
        r_div <= '0;
        r_pos <= (r_pos == 4'(POS_MAX)) ? '0 : r_pos + 4'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // Leftmost digit shows char pos; characters past the message end are blank.
  always_comb begin
    w_hex = '1;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      int unsigned c;
      c = 32'(r_pos) + NUM_DIGITS - 1 - k;
      if (!w_empty && (c < 9)) w_hex[7*k +: 7] = w_msg[c[3:0]];
    end
  end

  // Registered segment outputs.
  always_ff @(posedge clk) begin
    if (reset) r_hex <= '1;
    else       r_hex <= w_hex;
  end

  assign bus.hex = r_hex;
endmodule

// File: tb/tb_instr_scroll_disp.sv
// tb_instr_scroll_disp: directed plus random stimulus; a string-based reference model
// predicts hex/hist_idx per cycle into a queue consumed by a separate monitor.
module tb_instr_scroll_disp;
  localparam int N  = 6;
  localparam int HD = 4;
  localparam int SD = 4;
  localparam int HW = 7 * N;
  localparam int IW = $clog2(HD);
`ifdef INSTR_SCROLL_DISP_HIST_EN
  localparam int DEPTH = HD;
  localparam bit BROWSE = 1'b1;
`else
  localparam int DEPTH = 1;
  localparam bit BROWSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_scroll_disp_if #(.NUM_DIGITS(N), .HIST_DEPTH(HD)) bus ();
  instr_scroll_disp #(.NUM_DIGITS(N), .HIST_DEPTH(HD), .SCROLL_DIV(SD)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [HW-1:0] hex;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  logic [31:0]   hist[$];
  int            idx = 0;
  int            t = 0;
  logic [HW-1:0] prev_disp = '1;

  function automatic logic [6:0] glyph(input byte c);
    case (c)
      "A", "a": glyph = 7'b0001000;
      "d", "D": glyph = 7'b0100001;
      "I", "i": glyph = 7'b1001111;
      "S", "s": glyph = 7'b0010010;
      "t", "T": glyph = 7'b0000111;
      "E", "e": glyph = 7'b0000110;
      "n", "N": glyph = 7'b0101011;
      "r", "R": glyph = 7'b0101111;
      "O", "o": glyph = 7'b1000000;
      "L", "l": glyph = 7'b1000111;
      "U":      glyph = 7'b1000001;
      "u":      glyph = 7'b1100011;
      "b", "B": glyph = 7'b0000011;
      "q", "Q": glyph = 7'b0011000;
      "J", "j": glyph = 7'b1110001;
      "P", "p": glyph = 7'b0001100;
      "C", "c": glyph = 7'b1000110;
      "X", "x": glyph = 7'b0110111;
      "Y", "y": glyph = 7'b0010001;
      "G", "g": glyph = 7'b1000010;
      " ":      glyph = 7'b1111111;
      "0": glyph = 7'b1000000;
      "1": glyph = 7'b1111001;
      "2": glyph = 7'b0100100;
      "3": glyph = 7'b0110000;
      "4": glyph = 7'b0011001;
      "5": glyph = 7'b0010010;
      "6": glyph = 7'b0000010;
      "7": glyph = 7'b1111000;
      "8": glyph = 7'b0000000;
      "9": glyph = 7'b0010000;
      default: glyph = 7'b0000000;
    endcase
  endfunction

  function automatic string mnem(input logic [31:0] w, output bit rdv);
    string m;
    rdv = 1'b1;
    case (w[6:0])
      7'h33: case (w[14:12])
               3'd0: m = w[30] ? "sub" : "add";
               3'd1: m = "sll";
               3'd2: m = "slt";
               3'd4: m = "xor";
               3'd6: m = "or";
               3'd7: m = "and";
               default: m = "ALU";
             endcase
      7'h13: case (w[14:12])
               3'd0: m = "addI";
               3'd4: m = "xorI";
               3'd6: m = "orI";
               3'd7: m = "andI";
               default: m = "ALUI";
             endcase
      7'h03: m = "LOAd";
      7'h23: begin m = "StOr"; rdv = 1'b0; end
      7'h63: begin
               rdv = 1'b0;
               case (w[14:12])
                 3'd0: m = "bEq";
                 3'd1: m = "bnE";
                 3'd4: m = "bLt";
                 3'd5: m = "bGE";
                 default: m = "brA";
               endcase
             end
      7'h6F: m = "JAL";
      7'h67: m = "JALr";
      7'h37: m = "LUI";
      7'h17: m = "AUIPC";
      7'h73: begin m = "SYStEn"; rdv = 1'b0; end
      default: begin m = ""; rdv = 1'b0; end
    endcase
    return m;
  endfunction

  function automatic logic [HW-1:0] disp();
    logic [HW-1:0] r;
    logic [31:0]   w;
    string         m;
    string         msg;
    bit            rdv;
    int            pos;
    int            c;
    r = '1;
    if (hist.size() == 0) return r;
    w = hist[hist.size() - 1 - idx];
    m = mnem(w, rdv);
    if (m.len() == 0) begin
      msg = "         ";
    end else begin
      msg = m;
      while (msg.len() < 6) msg = {msg, " "};
      msg = {msg, " "};
      if (rdv) msg = {msg, $sformatf("%02d", w[11:7])};
      else     msg = {msg, "  "};
    end
    pos = (t / SD) % (10 - N);
    for (int k = 0; k < N; k++) begin
      c = pos + N - 1 - k;
      if (c < 9) r[7*k +: 7] = glyph(msg[c]);
    end
    return r;
  endfunction

  task automatic model_edge(input logic rst, input logic v, input logic [31:0] ins,
                            input logic prv);
    exp_t e;
    bit   chg;
    e.hex = rst ? '1 : prev_disp;
    if (rst) begin
      hist.delete();
      idx = 0;
      t = 0;
    end else begin
      chg = 1'b0;
      if (v) begin
        hist.push_back(ins);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        if (idx == 0 || idx == DEPTH - 1) chg = 1'b1;
        else idx++;
      end else if (prv && BROWSE && hist.size() > 0) begin
        idx = (idx == hist.size() - 1) ? 0 : idx + 1;
        chg = 1'b1;
      end
      t = chg ? 0 : t + 1;
    end
    prev_disp = disp();
    e.idx = IW'(idx);
    q.push_back(e);
  endtask

  task automatic step(input logic rst, input logic v, input logic [31:0] ins, input logic prv);
    @(negedge clk);
    reset = rst;
    bus.instr_valid = v;
    bus.instr = ins;
    bus.hist_prev = prv;
    @(posedge clk);
    model_edge(rst, v, ins, prv);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] w;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h00};
    w = $urandom;
    w[6:0] = ops[$urandom_range(0, 11)];
    return w;
  endfunction

  // Monitor: compares registered outputs between edges against queued predictions.
  initial begin
    exp_t e;
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.hex !== e.hex) begin
          bad++;
          $display("FAIL hex cyc=%0d got=%b want=%b", cyc, bus.hex, e.hex);
        end
        total++;
        if (bus.hist_idx !== e.idx) begin
          bad++;
          $display("FAIL hist_idx cyc=%0d got=%0d want=%0d", cyc, bus.hist_idx, e.idx);
        end
      end
    end
  end

  initial begin
    bit r_rst, r_v, r_p;
    int r;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.hist_prev = 1'b0;
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    idle(3);
    // capture and scroll through every window position and back
    step(1'b0, 1'b1, 32'h00500093, 1'b0);
    idle(20);
    // no-rd and unknown opcodes
    step(1'b0, 1'b1, 32'h00112023, 1'b0);
    idle(18);
    step(1'b0, 1'b1, 32'h00000000, 1'b0);
    idle(6);
    // browse
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h00000033, 1'b0);
    step(1'b0, 1'b1, 32'h40000033, 1'b0);
    step(1'b0, 1'b1, 32'h00000073, 1'b0);
    idle(2);
    repeat (3) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      idle(5);
    end
    // capture while browsing, then capture coincident with hist_prev
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 32'h0000006F, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 32'h00A00513, 1'b1);
    idle(3);
    repeat (3) step(1'b0, 1'b1, 32'h00C58633, 1'b0);
    idle(3);
    // reset mid-scroll with a coincident capture, then a browse pulse on empty history
    step(1'b0, 1'b1, 32'h00500093, 1'b0);
    idle(9);
    step(1'b1, 1'b1, 32'h00500093, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 99);
      r_rst = (r == 0);
      r_v = (r >= 1 && r < 22);
      r_p = ($urandom_range(0, 4) == 0);
      step(r_rst, r_v, rand_instr(), r_p);
    end
    idle(2);
    repeat (4) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
